// File: rtl/apb_to_ahb_converter.sv
// APB3 slave that turns each APB transfer into one AHB-Lite SINGLE word transfer.
// Flow: APB setup -> AHB address phase -> AHB data phase -> one-cycle APB response.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for an APB setup cycle (psel=1, penable=0)
// ADDR   | AHB address phase, NONSEQ driven until hready
// DATA   | AHB data phase, write data driven, waiting for hready
// RESP   | APB pready pulse with the sampled AHB read data / error

module apb_to_ahb_converter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwdata,
    output logic [DATA_WIDTH-1:0] o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr,
    output logic [ADDR_WIDTH-1:0] o_haddr,
    output logic [2:0]            o_hburst,
    output logic                  o_hmastlock,
    output logic [3:0]            o_hprot,
    output logic [2:0]            o_hsize,
    output logic [1:0]            o_htrans,
    output logic [DATA_WIDTH-1:0] o_hwdata,
    output logic                  o_hwrite,
    input  logic [DATA_WIDTH-1:0] i_hrdata,
    input  logic                  i_hready,
    input  logic                  i_hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Only single, word-sized, unlocked, non-cacheable privileged data accesses are issued.
    assign o_hburst    = 3'b000;
    assign o_hsize     = 3'b010;
    assign o_hprot     = 4'b0011;
    assign o_hmastlock = 1'b0;

    // Sequencer; o_haddr/o_hwrite double as the captured address and direction.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            wdata_q   <= '0;
            o_haddr   <= '0;
            o_hwrite  <= 1'b0;
            o_htrans  <= HTRANS_IDLE;
            o_hwdata  <= '0;
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            o_prdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_psel && !i_penable) begin
                        state    <= ST_ADDR;
                        o_haddr  <= i_paddr;
                        o_hwrite <= i_pwrite;
                        wdata_q  <= i_pwdata;
                        o_htrans <= HTRANS_NONSEQ;
                    end
                end
                ST_ADDR: begin
                    // hresp during the address phase belongs to an earlier transfer; ignore it.
                    if (i_hready) begin
                        state    <= ST_DATA;
                        o_htrans <= HTRANS_IDLE;
                        o_hwdata <= o_hwrite ? wdata_q : '0;
                    end
                end
                ST_DATA: begin
                    // The first cycle of a two-cycle ERROR has hready low and is waited out.
                    if (i_hready) begin
                        state     <= ST_RESP;
                        o_hwdata  <= '0;
                        o_pready  <= 1'b1;
                        o_pslverr <= i_hresp;
                        o_prdata  <= (!o_hwrite && !i_hresp) ? i_hrdata : '0;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    o_pready  <= 1'b0;
                    o_pslverr <= 1'b0;
                    o_prdata  <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_to_ahb_converter.md
APB_TO_AHB_CONVERTER -- requirements
Module: apb_to_ahb_converter

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- ADDR_WIDTH, 32, address width on both ports
- DATA_WIDTH, 32, data width on both ports
REQ-002 Ports SHALL be (name direction width meaning):
- i_clk in 1 single clock, rising edge
- i_reset_n in 1 asynchronous active-low reset
- i_psel in 1 APB3 select
- i_penable in 1 APB3 enable
- i_pwrite in 1 H write / L read
- i_paddr in ADDR_WIDTH APB address
- i_pwdata in DATA_WIDTH APB write data
- o_prdata out DATA_WIDTH APB read data
- o_pready out 1 APB ready
- o_pslverr out 1 L OK / H error
- o_haddr out ADDR_WIDTH AHB address
- o_hburst out 3 burst type
- o_hmastlock out 1 locked transfer
- o_hprot out 4 protection
- o_hsize out 3 transfer size
- o_htrans out 2 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- o_hwdata out DATA_WIDTH AHB write data
- o_hwrite out 1 H write / L read
- i_hrdata in DATA_WIDTH AHB read data
- i_hready in 1 AHB bus ready
- i_hresp in 1 L OKAY / H ERROR
REQ-003 Block SHALL use one clock (i_clk); reset SHALL be asynchronous, active-low (i_reset_n).
REQ-004 All outputs SHALL be registered.

Function
REQ-005 Block SHALL be an APB3 slave converting each APB transfer into exactly one AHB-Lite single transfer.
REQ-006 Constant outputs: o_hburst=3'b000 (SINGLE), o_hsize=3'b010 (word), o_hprot=4'b0011, o_hmastlock=0; o_htrans SHALL never be BUSY or SEQ.
REQ-007 FSM states: IDLE, ADDR, DATA, RESP.
REQ-008 IDLE: on i_psel=1 and i_penable=0 (setup cycle, call it cycle 0), capture i_paddr, i_pwrite, i_pwdata; next state ADDR; otherwise stay in IDLE.
REQ-009 ADDR (cycle 1 onward): o_htrans=NONSEQ, o_haddr/o_hwrite = captured values, held stable; on i_hready=1 go to DATA, else stay.
REQ-010 DATA: o_htrans=IDLE; o_hwdata = captured write data for writes, 0 for reads; on i_hready=1 sample i_hrdata and i_hresp and go to RESP, else stay.
REQ-011 RESP: o_pready=1 for exactly one cycle; o_pslverr = sampled i_hresp; o_prdata = sampled i_hrdata for an OK read, 0 for writes and error responses; next state IDLE unconditionally.
REQ-012 Minimum latency: setup in cycle 0 -> o_pready=1 in cycle 3; each i_hready=0 cycle in ADDR or DATA adds one cycle.
REQ-013 o_pready, o_pslverr, o_prdata SHALL be 0 in every state except RESP.
REQ-014 AHB two-cycle error: i_hresp=1 with i_hready=0 in DATA SHALL be waited out; the error is taken from the cycle where i_hready=1.
REQ-015 i_hresp in ADDR SHALL be ignored.
REQ-016 If i_psel drops before RESP (protocol violation), the AHB transfer SHALL still complete; RESP SHALL still pulse; no new transfer SHALL start until IDLE.
REQ-017 A new setup in the cycle after RESP SHALL be accepted (back-to-back, no idle gap required).
REQ-018 o_haddr and o_hwrite SHALL hold their last values outside ADDR/DATA; o_hwdata SHALL return to 0 when leaving DATA.

Reset
REQ-019 On i_reset_n=0, immediately and regardless of state: FSM=IDLE, o_htrans=IDLE, o_pready=0, o_pslverr=0, o_prdata=0, o_haddr=0, o_hwdata=0, o_hwrite=0, capture registers=0; constant outputs per REQ-006.
REQ-020 A transfer interrupted by reset SHALL be dropped; after release, no o_pready until a new setup.

Verification
REQ-021 Write 0x1000_0010 data 0xDEADBEEF, i_hready=1 -> cycle1 htrans=2, haddr=0x10000010, hwrite=1; cycle2 htrans=0, hwdata=0xDEADBEEF; cycle3 pready=1, pslverr=0.
REQ-022 Read 0x0000_0004, i_hready=0 for 2 DATA cycles, i_hrdata=0x12345678 -> pready=1 in cycle 5, prdata=0x12345678, pslverr=0.
REQ-023 Read with i_hresp=1/i_hready=0 then i_hresp=1/i_hready=1 in DATA -> single pready=1 pulse, pslverr=1, prdata=0.
REQ-024 i_hready=0 for 1 cycle in ADDR -> htrans=NONSEQ and haddr stable for 2 cycles; pready in cycle 4.
REQ-025 Reset asserted in DATA -> htrans=0, hwdata=0, pready=0 same cycle; after release, idle until next setup.
REQ-026 Back-to-back write then read, setup immediately after pready -> two NONSEQ transfers, two pready pulses 4 cycles apart.
